// File: rtl/blink_code_gen.sv
// Status-code blink sequencer: replays a latched MSB-first binary code forever as
// long/short pulses with inter-symbol gaps and an inter-frame pause.
module blink_code_gen #(
    parameter int unsigned CODE_W    = 4,
    parameter int unsigned SHORT_CYC = 20,
    parameter int unsigned LONG_CYC  = 60,
    parameter int unsigned GAP_CYC   = 20,
    parameter int unsigned PAUSE_CYC = 200
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             code_valid,
    output logic                             code_ready,
    input  logic [CODE_W-1:0]                code_data,
    input  logic [$clog2(CODE_W+1)-1:0]      code_len,
    output logic                             led_out,
    output logic                             long_on,
    output logic                             frame_done,
    output logic                             busy
);

    localparam int unsigned LEN_W   = $clog2(CODE_W + 1);
    localparam int unsigned IDX_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int unsigned MAX_LG  = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
    localparam int unsigned MAX_CYC = (MAX_LG > PAUSE_CYC) ? MAX_LG : PAUSE_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   len_in;
    logic               accept;
    logic               led_d, long_d, done_d, busy_d, ready_d;

    // Counter holds remaining cycles minus one, so a segment ends when it reads zero.
    function automatic logic [CNT_W-1:0] sym_load(input logic bit_v);
        return bit_v ? CNT_W'(LONG_CYC - 1) : CNT_W'(SHORT_CYC - 1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        code_d  = code_q;
        len_d   = len_q;
        accept  = code_valid && code_ready;
        len_in  = (code_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : code_len;

        case (state_q)
            ON: begin
                if (cnt_q == '0) begin
                    if (idx_q == '0) begin
                        state_d = PAUSE;
                        cnt_d   = CNT_W'(PAUSE_CYC - 1);
                    end else begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = ON;
                    cnt_d   = sym_load(code_q[idx_d]);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PAUSE: begin
                if (cnt_q == '0) begin
                    idx_d   = IDX_W'(len_q - LEN_W'(1));
                    state_d = ON;
                    cnt_d   = sym_load(code_q[idx_d]);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        // A new code overrides whatever the pause was doing.
        if (accept) begin
            code_d = code_data;
            len_d  = len_in;
            if (len_in != '0) begin
                idx_d   = IDX_W'(len_in - LEN_W'(1));
                state_d = ON;
                cnt_d   = sym_load(code_data[idx_d]);
            end else begin
                idx_d   = '0;
                state_d = IDLE;
                cnt_d   = '0;
            end
        end

        led_d   = (state_d == ON);
        long_d  = ((state_d == ON) || (state_d == GAP)) && code_d[idx_d];
        done_d  = (state_d == PAUSE) && (cnt_d == '0);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) || (state_d == PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            code_q     <= '0;
            len_q      <= '0;
            led_out    <= 1'b0;
            long_on    <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            code_ready <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            code_q     <= code_d;
            len_q      <= len_d;
            led_out    <= led_d;
            long_on    <= long_d;
            frame_done <= done_d;
            busy       <= busy_d;
            code_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_blink_code_gen.sv
// Scoreboard bench for blink_code_gen: a per-cycle expected waveform is queued on
// each accepted code and compared against the DUT outputs every cycle.
module tb_blink_code_gen;

    localparam int unsigned T_SHORT = 2;
    localparam int unsigned T_LONG  = 5;
    localparam int unsigned T_GAP   = 3;
    localparam int unsigned T_PAUSE = 10;

    typedef struct packed {
        logic led;
        logic lon;
        logic fd;
        logic busy;
        logic rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst_n;
    logic       code_valid;
    logic       code_ready;
    logic [3:0] code_data;
    logic [2:0] code_len;
    logic       led_out;
    logic       long_on;
    logic       frame_done;
    logic       busy;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [3:0] m_code;
    int         m_len;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         fd_cnt = 0;
    int         fd_last = 0;
    int         fd_period = 0;
    int         waits;
    int         fd_base;

    blink_code_gen #(
        .CODE_W   (4),
        .SHORT_CYC(T_SHORT),
        .LONG_CYC (T_LONG),
        .GAP_CYC  (T_GAP),
        .PAUSE_CYC(T_PAUSE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .code_data (code_data),
        .code_len  (code_len),
        .led_out   (led_out),
        .long_on   (long_on),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = clk_run ? ~clk : clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(input logic led, input logic lon, input logic fd,
                                input logic bsy, input logic rdy);
        exp_t e;
        e.led  = led;
        e.lon  = lon;
        e.fd   = fd;
        e.busy = bsy;
        e.rdy  = rdy;
        return e;
    endfunction

    // One full frame of the current model code, or a single idle cycle when blank.
    task automatic push_frame();
        logic b;
        int   n;
        if (m_len == 0) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            for (int i = m_len - 1; i >= 0; i--) begin
                b = m_code[i];
                n = b ? T_LONG : T_SHORT;
                for (int k = 0; k < n; k++) exp_q.push_back(mk(1'b1, b, 1'b0, 1'b1, 1'b0));
                if (i != 0)
                    for (int k = 0; k < T_GAP; k++) exp_q.push_back(mk(1'b0, b, 1'b0, 1'b1, 1'b0));
            end
            for (int k = 0; k < T_PAUSE; k++)
                exp_q.push_back(mk(1'b0, 1'b0, (k == T_PAUSE - 1), 1'b1, 1'b1));
        end
    endtask

    task automatic tick(output bit acc);
        acc = 1'b0;
        @(posedge clk);
        if (code_valid && cur.rdy) begin
            acc = 1'b1;
            exp_q.delete();
            m_code = code_data;
            m_len  = (code_len > 3'd4) ? 4 : int'(code_len);
        end
        if (exp_q.size() == 0) push_frame();
        #1;
        cyc++;
        cur = exp_q.pop_front();
        check("led_out",    32'(led_out),    32'(cur.led));
        check("long_on",    32'(long_on),    32'(cur.lon));
        check("frame_done", 32'(frame_done), 32'(cur.fd));
        check("busy",       32'(busy),       32'(cur.busy));
        check("code_ready", 32'(code_ready), 32'(cur.rdy));
        if (frame_done) begin
            fd_cnt++;
            fd_period = cyc - fd_last;
            fd_last   = cyc;
        end
    endtask

    task automatic run(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic offer(input logic [3:0] d, input logic [2:0] l, output int w);
        bit acc;
        code_valid = 1'b1;
        code_data  = d;
        code_len   = l;
        acc = 1'b0;
        w   = 0;
        while (!acc && w < 100) begin
            tick(acc);
            w++;
        end
        code_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b1;
        code_valid = 1'b0;
        code_data  = '0;
        code_len   = '0;
        m_code     = '0;
        m_len      = 0;
        cur        = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_led",   32'(led_out),    32'd0);
        check("rst_long",  32'(long_on),    32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_ready", 32'(code_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // Basic frame 0101 len 3, repeated twice
        offer(4'b0101, 3'd3, waits);
        check("basic_wait", 32'(waits), 32'd1);
        run(27);
        check("basic_fd_at_28", 32'(frame_done), 32'd1);
        run(29);

        // Backpressure: held offer waits through ON/GAP, taken on first PAUSE cycle
        offer(4'b1000, 3'd4, waits);
        check("bp_wait", 32'(waits), 32'd19);
        fd_base = fd_cnt;

        // Offer exactly on the last PAUSE cycle
        run(29);
        check("bnd_fd_once", 32'(fd_cnt - fd_base), 32'd1);
        offer(4'b0110, 3'd2, waits);
        check("bnd_wait", 32'(waits), 32'd1);
        run(19);

        // Blank code
        fd_base = fd_cnt;
        offer(4'b1010, 3'd0, waits);
        check("blank_wait", 32'(waits), 32'd1);
        run(40);
        check("blank_no_fd", 32'(fd_cnt - fd_base), 32'd0);
        check("blank_busy",  32'(busy), 32'd0);

        // Full width and clamped length
        offer(4'b1111, 3'd4, waits);
        run(77);
        check("full_period", 32'(fd_period), 32'd39);
        offer(4'b1111, 3'd7, waits);
        check("clamp_wait", 32'(waits), 32'd1);
        run(77);
        check("clamp_period", 32'(fd_period), 32'd39);

        // Asynchronous reset mid-ON with the clock stopped
        offer(4'b0101, 3'd3, waits);
        run(2);
        #5;
        clk_run = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("arst_led",   32'(led_out),    32'd0);
        check("arst_long",  32'(long_on),    32'd0);
        check("arst_busy",  32'(busy),       32'd0);
        check("arst_ready", 32'(code_ready), 32'd1);
        #20;
        rst_n = 1'b1;
        #1;
        clk_run = 1'b1;
        exp_q.delete();
        m_len = 0;
        cur   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        fd_base = fd_cnt;
        run(15);
        check("post_rst_no_fd", 32'(fd_cnt - fd_base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
